// File: rtl/vga_fb_reader.sv
// Framebuffer fetch: Avalon-MM burst reads from SDRAM into a show-ahead FIFO,
// presented as a valid/ready pixel stream tagged with start-of-frame.
//
// state       | meaning
// S_IDLE      | waiting for BURST words of free FIFO space
// S_REQ       | avm_read asserted, address held until waitrequest drops
// S_WAIT_DATA | burst accepted, collecting BURST readdatavalid beats
module vga_fb_reader #(
    parameter int          HDISP = 800,
    parameter int          VDISP = 480,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          BURST = 16,
    parameter int          DEPTH = 256
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic [5:0]  avm_burstcount,
    output logic [3:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic [23:0] pix_rgb,
    output logic        pix_sof,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        underflow
);
    localparam int FRAME = HDISP * VDISP;
    localparam int IDX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [31:0]      STRIDE    = 32'(4 * BURST);
    localparam logic [31:0]      LAST_ADDR = BASE + 32'(4 * (FRAME - BURST));
    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(DEPTH - BURST);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME - 1);
    localparam logic [5:0]       BEAT_LAST = 6'(BURST - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_DATA} state_t;

    state_t             state_q, state_d;
    logic               read_q, read_d;
    logic [31:0]        addr_q, addr_d;
    logic [5:0]         beat_q, beat_d;
    logic [IDX_W-1:0]   widx_q, widx_d;
    logic               wr_v_q, wr_v_d;
    logic [24:0]        wr_data_q, wr_data_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               underflow_q, underflow_d;
    logic [24:0]        mem_q [DEPTH];

    logic               beat_acc;
    logic               push;
    logic               pop;
    logic [CNT_W-1:0]   occupancy;
    logic               unused_hi;

    assign unused_hi = ^avm_readdata[31:24];

    assign pix_valid  = (count_q != '0);
    assign push       = wr_v_q;
    assign pop        = pix_valid & pix_ready;
    assign beat_acc   = (state_q == S_WAIT_DATA) & avm_readdatavalid;
    // A beat still in the input register already owns a FIFO slot.
    assign occupancy  = count_q + CNT_W'(wr_v_q);

    always_comb begin
        state_d     = state_q;
        read_d      = read_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        widx_d      = widx_q;
        wr_v_d      = beat_acc;
        wr_data_d   = {(widx_q == '0), avm_readdata[23:0]};
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        underflow_d = underflow_q | (pix_ready & ~pix_valid);

        if (beat_acc) begin
            widx_d = (widx_q == IDX_LAST) ? '0 : widx_q + IDX_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (occupancy <= FILL_MAX) begin
                    state_d = S_REQ;
                    read_d  = 1'b1;
                end
            end
            S_REQ: begin
                if (!avm_waitrequest) begin
                    state_d = S_WAIT_DATA;
                    read_d  = 1'b0;
                    beat_d  = '0;
                end
            end
            S_WAIT_DATA: begin
                if (beat_acc) begin
                    beat_d = beat_q + 6'd1;
                    if (beat_q == BEAT_LAST) begin
                        state_d = S_IDLE;
                        addr_d  = (addr_q == LAST_ADDR) ? BASE : addr_q + STRIDE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
            end
        endcase

        if (push) wptr_d = wptr_q + PTR_W'(1);
        if (pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!pixel_rst_n) begin
            state_q     <= S_IDLE;
            read_q      <= 1'b0;
            addr_q      <= BASE;
            beat_q      <= '0;
            widx_q      <= '0;
            wr_v_q      <= 1'b0;
            wr_data_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            widx_q      <= widx_d;
            wr_v_q      <= wr_v_d;
            wr_data_q   <= wr_data_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst_n && push) begin
            mem_q[wptr_q] <= wr_data_q;
        end
    end

    assign {pix_sof, pix_rgb} = mem_q[rptr_q];
    assign avm_address        = addr_q;
    assign avm_read           = read_q;
    assign avm_burstcount     = 6'(BURST);
    assign avm_byteenable     = 4'hF;
    assign underflow          = underflow_q;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: Avalon slave model feeding a scoreboard
// of expected pixels, checked on every pop of the pixel stream.
module tb_vga_fb_reader;
    localparam int FRAME = 32 * 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [5:0]  avm_burstcount;
    logic [3:0]  avm_byteenable;
    logic        wr;
    logic [31:0] rdata;
    logic        rdv;
    logic [23:0] pix_rgb;
    logic        pix_sof;
    logic        pix_valid;
    logic        pix_ready;
    logic        underflow;

    int n_tests = 0;
    int n_fail  = 0;
    int accept_cnt = 0;
    int sof_cnt = 0;
    logic [31:0] last_acc = '0;
    logic [31:0] exp_next = '0;
    bit sb_en = 1'b1;
    logic [24:0] exp_q [$];

    vga_fb_reader #(
        .HDISP(32), .VDISP(16), .BASE(32'h0), .BURST(16), .DEPTH(256)
    ) dut (
        .pixel_clk        (clk),
        .pixel_rst_n      (rst_n),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_burstcount   (avm_burstcount),
        .avm_byteenable   (avm_byteenable),
        .avm_waitrequest  (wr),
        .avm_readdata     (rdata),
        .avm_readdatavalid(rdv),
        .pix_rgb          (pix_rgb),
        .pix_sof          (pix_sof),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .underflow        (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Slave: data word = byte address / 4, first beat two cycles after accept.
    initial begin
        logic [31:0] burst_addr;
        logic [31:0] d;
        int delay, beats_left, beat_i;
        burst_addr = '0; delay = 0; beats_left = 0; beat_i = 0;
        rdv = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (beats_left > 0) begin
                if (delay > 1) begin
                    delay--;
                    rdv = 1'b0;
                end else begin
                    d = burst_addr / 4 + 32'(beat_i);
                    rdv = 1'b1;
                    rdata = {8'hA5, d[23:0]};
                    if (sb_en) exp_q.push_back({(d % FRAME) == 0, d[23:0]});
                    beat_i++;
                    beats_left--;
                end
            end else begin
                rdv = 1'b0;
            end
            if (avm_read && !wr && rst_n) begin
                accept_cnt++;
                last_acc = avm_address;
                chk("accept_addr", avm_address, exp_next);
                exp_next = (avm_address + 32'h40) % 32'h800;
                burst_addr = avm_address;
                delay = 2;
                beats_left = 16;
                beat_i = 0;
            end
        end
    end

    // Pop monitor: every accepted pixel must match the head of the scoreboard.
    initial begin
        logic [24:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {pix_sof, pix_rgb}, e);
                    if (pix_sof) sof_cnt++;
                end
            end
        end
    end

    initial begin
        int i;
        rst_n = 1'b0;
        wr = 1'b1;
        pix_ready = 1'b0;
        tick(3);
        chk("rst_read", avm_read, 1'b0);
        chk("rst_addr", avm_address, 32'h0);
        chk("rst_valid", pix_valid, 1'b0);
        chk("rst_underflow", underflow, 1'b0);
        chk("burstcount", avm_burstcount, 6'd16);
        chk("byteenable", avm_byteenable, 4'hF);

        rst_n = 1'b1;
        tick(1);
        chk("first_req", avm_read, 1'b1);
        chk("first_addr", avm_address, 32'h0);
        pix_ready = 1'b1;
        tick(1);
        chk("underflow_set", underflow, 1'b1);
        chk("valid_empty", pix_valid, 1'b0);
        pix_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("stall_read", avm_read, 1'b1);
            chk("stall_addr", avm_address, 32'h0);
        end
        chk("stall_no_accept", accept_cnt, 0);
        wr = 1'b0;
        tick(1);
        chk("accept_once", accept_cnt, 1);
        chk("read_drop", avm_read, 1'b0);
        tick(2);
        chk("latency_min", pix_valid, 1'b0);

        // Fill with no consumer: exactly DEPTH/BURST bursts.
        tick(450);
        chk("fill_bursts", accept_cnt, 16);
        chk("fill_last_addr", last_acc, 32'h3C0);
        chk("fill_read_idle", avm_read, 1'b0);
        chk("head_rgb0", pix_rgb, 24'h000000);
        chk("head_sof0", pix_sof, 1'b1);
        chk("underflow_sticky", underflow, 1'b1);

        pix_ready = 1'b1;
        tick(15);
        pix_ready = 1'b0;
        tick(10);
        chk("no_req_15pop", accept_cnt, 16);
        pix_ready = 1'b1;
        tick(1);
        pix_ready = 1'b0;
        chk("head_rgb16", pix_rgb, 24'h000010);
        chk("head_sof16", pix_sof, 1'b0);
        for (i = 0; i < 10 && accept_cnt < 17; i++) tick(1);
        chk("req_after_16pop", accept_cnt, 17);
        chk("req_addr_400", last_acc, 32'h400);

        // Continuous consumption across the frame wrap.
        pix_ready = 1'b1;
        for (i = 0; i < 2000 && accept_cnt < 36; i++) tick(1);
        chk("wrap_accepts", accept_cnt, 36);
        wr = 1'b1;
        for (i = 0; i < 500 && exp_q.size() != 0; i++) tick(1);
        chk("drain_done", 64'(exp_q.size()), 64'd0);
        chk("sof_count", sof_cnt, 2);
        chk("underflow_hold", underflow, 1'b1);

        // Reset in the middle of a burst; late beats must be ignored.
        pix_ready = 1'b0;
        wr = 1'b0;
        for (i = 0; i < 20 && !rdv; i++) tick(1);
        chk("midburst_beat", rdv, 1'b1);
        wr = 1'b1;
        sb_en = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_read", avm_read, 1'b0);
        chk("mid_rst_valid", pix_valid, 1'b0);
        chk("mid_rst_addr", avm_address, 32'h0);
        chk("mid_rst_underflow", underflow, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            chk("late_beat_ignored", pix_valid, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_reader.md
Name: vga_fb_reader

Overview:
Framebuffer fetch stage directly upstream of the VGA timing generator. It reads a frame of 32-bit pixel words from SDRAM over an Avalon-MM burst read master and buffers them in an internal FIFO. It presents them as a valid/ready pixel stream with a start-of-frame tag. The VGA stage pops one pixel per active (BLANK=1) cycle.
Single clock domain: the Avalon master and the pixel stream both run on pixel_clk.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
BASE, 32'h0000_0000, byte address of pixel (0,0); must be 4-byte aligned
BURST, 16, words per Avalon read burst; HDISP*VDISP must be a multiple of BURST; BURST <= 63
DEPTH, 256, FIFO depth in words; power of 2; DEPTH >= 2*BURST

Ports:
pixel_clk  in  1  clock for all logic
pixel_rst_n  in  1  synchronous active-low reset
avm_address  out  32  byte address of current burst
avm_read  out  1  read request
avm_burstcount  out  6  constant BURST
avm_byteenable  out  4  constant 4'hF
avm_waitrequest  in  1  slave stall
avm_readdata  in  32  read data beat
avm_readdatavalid  in  1  beat valid
pix_rgb  out  24  pixel at FIFO head = word[23:0]
pix_sof  out  1  head pixel is pixel (0,0) of a frame
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  consumer pops head this cycle
underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (sampled on pixel_clk edge while pixel_rst_n=0): state IDLE, avm_read=0, avm_address=BASE, FIFO count=0, write/read pointers=0, word index=0, beat counter=0, underflow=0, pix_valid=0. Reset mid-burst abandons the burst; any late readdatavalid beats after reset release are ignored until the next REQ is accepted.
- FSM, three states:
  - IDLE -> REQ when (DEPTH - count) >= BURST. Evaluated every cycle.
  - REQ: avm_read=1. avm_address and burstcount are held stable while avm_waitrequest=1. When avm_waitrequest=0 the request is accepted: avm_read=0 next cycle, beat counter cleared, -> WAIT_DATA.
  - WAIT_DATA: each avm_readdatavalid=1 pushes {tag, readdata[23:0]} into the FIFO and increments the beat counter. On the BURST-th beat: avm_address += 4*BURST, -> IDLE.
- Only one burst is outstanding at a time. Free space is reserved at the IDLE->REQ decision, so a push never meets a full FIFO.
- Address wrap: when the frame's last burst completes (address = BASE + 4*(HDISP*VDISP - BURST)), the next avm_address is BASE.
- Tag: the write-side word index counts 0..HDISP*VDISP-1 and wraps to 0. tag=1 only for index 0. pix_sof = tag of head entry.
- FIFO: show-ahead. pix_rgb and pix_sof are valid combinationally from the head whenever pix_valid=1. Pop occurs when pix_valid & pix_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Pop from a full FIFO concurrent with a push is legal.
- pix_ready=1 with pix_valid=0: no pointer change, underflow<=1. underflow stays set until reset.
- Latency: first pix_valid no earlier than 2 cycles after the first readdatavalid beat is sampled (register + FIFO write); no earlier than 4 cycles after reset release with zero waitrequest and 1-cycle read latency.
- Widths: count is clog2(DEPTH)+1 bits. Word index is clog2(HDISP*VDISP) bits. Address arithmetic is 32-bit modulo.

Test Plan:
- Reset release, slave with waitrequest=0 and readdata=address/4 returned 2 cycles after accept -> first request at address 0x0, burstcount 16; first popped pixel 24'h000000 with pix_sof=1; 17th pixel 24'h000010, pix_sof=0.
- pix_ready held 0 -> exactly DEPTH/BURST=16 bursts issued (last at 0x3C0), then avm_read stays 0. Pop 15 words -> no new request. Pop 16th -> request at 0x400.
- Small frame HDISP=8, VDISP=4, BURST=8, continuous pop -> addresses 0x00, 0x20, 0x40, 0x60, 0x00; pix_sof=1 on pixels 0 and 32 only.
- waitrequest held 1 for 5 cycles in REQ -> avm_read and avm_address stable all 5 cycles; one accept only; 16 beats pushed.
- FIFO at DEPTH-16 with burst arriving and pix_ready=1 every cycle -> count constant during beats; no data lost or reordered.
- pix_ready=1 after reset before any data -> underflow=1 and stays 1. Assert pixel_rst_n=0 mid-burst -> avm_read=0, pix_valid=0, address BASE next cycle; underflow=0.
